jtframe_spi_dwnld: RTL and testbench
====================================

JTFRAME_SPI_DWNLD -- requirements
Module: jtframe_spi_dwnld

Interface
REQ-001 SHALL have parameter AW, default 25: width of ioctl_addr.
REQ-002 SHALL have parameter CMD_IDX, default 8'h55: command that sets the file index.
REQ-003 SHALL have parameter CMD_TX, default 8'h53: command that starts or ends a download.
REQ-004 SHALL have parameter CMD_DAT, default 8'h54: command that carries the data stream.
REQ-005 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port SPI_SCK, input, 1: SPI clock from the IO controller, asynchronous to clk.
REQ-008 SHALL have port SPI_SS2, input, 1: active-low frame select for the data channel.
REQ-009 SHALL have port SPI_DI, input, 1: serial data, MSB first, valid on the SCK rising edge.
REQ-010 SHALL have port ioctl_index, output, 8: latched file index.
REQ-011 SHALL have port downloading, output, 1: download in progress.
REQ-012 SHALL have port ioctl_addr, output, AW: byte address of ioctl_dout.
REQ-013 SHALL have port ioctl_dout, output, 8: downloaded byte.
REQ-014 SHALL have port ioctl_wr, output, 1: one-clk write strobe.
REQ-015 SHALL have port overflow, output, 1: sticky flag, address space exhausted.

Function
REQ-016 SHALL pass SPI_SCK, SPI_SS2 and SPI_DI each through a 2-flop synchronizer before use; the SCK rising edge is detected on the synchronized signal.
REQ-017 SHALL operate correctly when SCK high and low phases each last at least 3 clk periods.
REQ-018 SHALL, when synchronized SS2 is high, hold the bit counter at 0 and the state at IDLE, discarding any partial byte.
REQ-019 SHALL shift one DI bit per detected SCK rising edge into an 8-bit register; the 8th bit completes a byte.
REQ-020 SHALL use states IDLE, CMD and PAYLOAD: IDLE->CMD on SS2 low; CMD->PAYLOAD on the first completed byte, which is latched as the command; PAYLOAD persists until SS2 high, then IDLE.
REQ-021 SHALL, for CMD_IDX, copy the first payload byte to ioctl_index and ignore any further payload bytes.
REQ-022 SHALL, for CMD_TX, on the first payload byte: nonzero sets downloading=1, ioctl_addr=0 and overflow=0; zero sets downloading=0. A start while already downloading restarts at address 0. An end while idle is a no-op.
REQ-023 SHALL, for CMD_DAT with downloading=1 and overflow=0, emit every payload byte on ioctl_dout with ioctl_wr high for exactly one clk.
REQ-024 SHALL hold ioctl_addr stable during the ioctl_wr cycle and increment it by 1 on the clk after.
REQ-025 SHALL keep the first byte of a download at address 0.
REQ-026 SHALL continue addresses across multiple CMD_DAT frames without reset.
REQ-027 SHALL assert ioctl_wr on the 4th rising clk edge after the clk edge that first samples SPI_SCK high for the 8th bit; this latency is fixed.
REQ-028 SHALL ignore CMD_DAT bytes while downloading=0; no ioctl_wr results.
REQ-029 SHALL ignore payload bytes of unknown commands.
REQ-030 SHALL, after a write at address 2^AW-1, set overflow=1, leave ioctl_addr at 2^AW-1, and suppress further writes until the next CMD_TX start.
REQ-031 SHALL leave downloading, ioctl_index and ioctl_addr unchanged when SS2 rises mid-byte.

Reset
REQ-032 SHALL, on rst high at any time, including mid-download, asynchronously clear: ioctl_index=0, downloading=0, ioctl_addr=0, ioctl_dout=0, ioctl_wr=0, overflow=0, bit counter=0, state=IDLE.
REQ-033 SHALL resume normal operation on the first clk edge after rst falls and wait for a new SS2 frame.

Verification
REQ-034 Bench SHALL cover: frame {55,05} -> ioctl_index=8'h05; downloading stays 0; no ioctl_wr.
REQ-035 Bench SHALL cover: frames {53,01},{54,AA,BB,CC},{53,00} -> writes (0,AA),(1,BB),(2,CC), each one clk wide; downloading 1 then 0; final ioctl_addr=3.
REQ-036 Bench SHALL cover: {54,11} with downloading=0 -> no ioctl_wr; ioctl_addr stays 0.
REQ-037 Bench SHALL cover: SS2 raised after 5 bits of a data byte, then {54,22} -> only 8'h22 is written, at the next address.
REQ-038 Bench SHALL cover: AW=4, 17 data bytes -> 16 writes at addresses 0..15, overflow=1, 17th byte suppressed.
REQ-039 Bench SHALL cover: rst pulse mid-byte during a download -> all outputs 0 immediately; a subsequent {53,01},{54,5A} writes 5A at address 0.

Source files
------------

// File: rtl/jtframe_spi_dwnld.sv
// ---------------------------------------------------------------------------
// jtframe_spi_dwnld
// Receives file downloads from an IO controller over a slave SPI link and
// turns the data stream into byte writes on an ioctl-style bus.
//
// Each SS2-low frame carries one command byte followed by payload bytes:
//   CMD_IDX : first payload byte becomes ioctl_index
//   CMD_TX  : first payload byte nonzero starts a download (address 0),
//             zero ends it
//   CMD_DAT : every payload byte is written out while a download is active
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          asynchronous active-high reset
//   SPI_SCK      SPI clock, asynchronous to clk
//   SPI_SS2      active-low frame select
//   SPI_DI       serial data, MSB first, sampled on SCK rising edge
//   ioctl_index  latched file index
//   downloading  high while a download is in progress
//   ioctl_addr   byte address of ioctl_dout
//   ioctl_dout   downloaded byte
//   ioctl_wr     one-clk write strobe
//   overflow     sticky: address space exhausted during this download
// ---------------------------------------------------------------------------
module jtframe_spi_dwnld #(
    parameter int          AW      = 25,
    parameter logic [7:0]  CMD_IDX = 8'h55,
    parameter logic [7:0]  CMD_TX  = 8'h53,
    parameter logic [7:0]  CMD_DAT = 8'h54
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SPI_SCK,
    input  logic          SPI_SS2,
    input  logic          SPI_DI,
    output logic [7:0]    ioctl_index,
    output logic          downloading,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic          ioctl_wr,
    output logic          overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

    // Synchronizer chains; SS2 rests high so the frame logic starts idle.
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic ss_meta_q, ss_sync_q;
    logic di_meta_q, di_sync_q;
    logic sck_rise_s;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_done_q, byte_done_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          first_q, first_d;
    logic          wr_pend_q, wr_pend_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic [7:0]    index_q, index_d;
    logic          dl_q, dl_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    dout_q, dout_d;
    logic          wr_q, wr_d;
    logic          ovf_q, ovf_d;

    // Two-flop synchronizers plus the SCK history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            ss_meta_q  <= 1'b1;
            ss_sync_q  <= 1'b1;
            di_meta_q  <= 1'b0;
            di_sync_q  <= 1'b0;
        end else begin
            sck_meta_q <= SPI_SCK;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            ss_meta_q  <= SPI_SS2;
            ss_sync_q  <= ss_meta_q;
            di_meta_q  <= SPI_DI;
            di_sync_q  <= di_meta_q;
        end
    end

    assign sck_rise_s = sck_sync_q & ~sck_prev_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            byte_q      <= 8'h00;
            byte_done_q <= 1'b0;
            cmd_q       <= 8'h00;
            first_q     <= 1'b0;
            wr_pend_q   <= 1'b0;
            pend_data_q <= 8'h00;
            index_q     <= 8'h00;
            dl_q        <= 1'b0;
            addr_q      <= {AW{1'b0}};
            dout_q      <= 8'h00;
            wr_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            byte_q      <= byte_d;
            byte_done_q <= byte_done_d;
            cmd_q       <= cmd_d;
            first_q     <= first_d;
            wr_pend_q   <= wr_pend_d;
            pend_data_q <= pend_data_d;
            index_q     <= index_d;
            dl_q        <= dl_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            wr_q        <= wr_d;
            ovf_q       <= ovf_d;
        end
    end

    // Byte assembly, frame FSM and command decode.
    // Pipeline from the synchronized SCK edge: byte_done -> wr_pend -> wr,
    // which gives a fixed four-clk latency from the first sample of SCK high.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        byte_d      = byte_q;
        byte_done_d = 1'b0;
        cmd_d       = cmd_q;
        first_d     = first_q;
        wr_pend_d   = 1'b0;
        pend_data_d = pend_data_q;
        index_d     = index_q;
        dl_d        = dl_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        wr_d        = wr_pend_q;
        ovf_d       = ovf_q;

        // Deasserted frame select discards any partial byte.
        if (ss_sync_q) begin
            bit_cnt_d = 3'd0;
        end else if (sck_rise_s) begin
            shreg_d   = {shreg_q[6:0], di_sync_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_d      = {shreg_q[6:0], di_sync_q};
                byte_done_d = 1'b1;
            end else begin
                byte_done_d = 1'b0;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        // Address advances on the clk after the strobe; the last address
        // is kept and the download is flagged as overflowed instead.
        if (wr_q) begin
            if (addr_q == ADDR_MAX) begin
                ovf_d = 1'b1;
            end else begin
                addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
            end
        end else begin
            addr_d = addr_q;
        end

        if (wr_pend_q) begin
            dout_d = pend_data_q;
        end else begin
            dout_d = dout_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!ss_sync_q) begin
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (ss_sync_q) begin
                    state_d = ST_IDLE;
                end else if (byte_done_q) begin
                    cmd_d   = byte_q;
                    first_d = 1'b1;
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_PAYLOAD: begin
                // A byte completed just before SS2 rose is still honoured.
                if (byte_done_q) begin
                    first_d = 1'b0;
                    if (cmd_q == CMD_IDX) begin
                        if (first_q) begin
                            index_d = byte_q;
                        end else begin
                            index_d = index_q;
                        end
                    end else if (cmd_q == CMD_TX) begin
                        if (first_q) begin
                            if (byte_q != 8'h00) begin
                                dl_d   = 1'b1;
                                addr_d = {AW{1'b0}};
                                ovf_d  = 1'b0;
                            end else begin
                                dl_d   = 1'b0;
                            end
                        end else begin
                            dl_d = dl_q;
                        end
                    end else if (cmd_q == CMD_DAT) begin
                        if (dl_q && !ovf_q) begin
                            wr_pend_d   = 1'b1;
                            pend_data_d = byte_q;
                        end else begin
                            wr_pend_d   = 1'b0;
                        end
                    end else begin
                        wr_pend_d = 1'b0;
                    end
                end else begin
                    first_d = first_q;
                end
                if (ss_sync_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ioctl_index = index_q;
    assign downloading = dl_q;
    assign ioctl_addr  = addr_q;
    assign ioctl_dout  = dout_q;
    assign ioctl_wr    = wr_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_jtframe_spi_dwnld.sv
// Bench for jtframe_spi_dwnld: two instances (AW=25 and AW=4) share one SPI
// link. A byte-level reference model predicts every write (address, data,
// clk cycle) into per-instance queues; monitors pop and compare on each
// ioctl_wr. Register outputs are compared after every frame.
module tb_jtframe_spi_dwnld;

    localparam int HALF = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic SPI_SCK = 1'b0;
    logic SPI_SS2 = 1'b1;
    logic SPI_DI  = 1'b0;

    logic [7:0]  index0, index1, dout0, dout1;
    logic        dl0, dl1, wr0, wr1, ovf0, ovf1;
    logic [24:0] addr0;
    logic [3:0]  addr1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    exp_t exp0[$];
    exp_t exp1[$];
    logic [7:0] frame_q[$];

    // Reference model state, one slot per instance.
    logic        m_dl[2];
    logic        m_ovf[2];
    logic [7:0]  m_idx[2];
    int          m_addr[2];
    int          m_max[2];
    logic [7:0]  m_cmd;

    logic wr0_prev = 1'b0;
    logic wr1_prev = 1'b0;

    jtframe_spi_dwnld #(.AW(25)) u_dut0 (
        .clk(clk), .rst(rst), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
        .ioctl_index(index0), .downloading(dl0), .ioctl_addr(addr0),
        .ioctl_dout(dout0), .ioctl_wr(wr0), .overflow(ovf0)
    );

    jtframe_spi_dwnld #(.AW(4)) u_dut1 (
        .clk(clk), .rst(rst), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
        .ioctl_index(index1), .downloading(dl1), .ioctl_addr(addr1),
        .ioctl_dout(dout1), .ioctl_wr(wr1), .overflow(ovf1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor, AW=25 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wr0) begin
            chk("wr0_width", 64'(wr0_prev), 64'd0);
            if (exp0.size() == 0) begin
                chk("wr0_unexpected", 64'(addr0), 64'hFFFF_FFFF);
            end else begin
                e = exp0.pop_front();
                chk("wr0_addr", 64'(addr0), 64'(e.addr));
                chk("wr0_data", 64'(dout0), 64'(e.data));
                chk("wr0_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        wr0_prev <= wr0;
    end

    // Monitor, AW=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wr1) begin
            chk("wr1_width", 64'(wr1_prev), 64'd0);
            if (exp1.size() == 0) begin
                chk("wr1_unexpected", 64'(addr1), 64'hFFFF_FFFF);
            end else begin
                e = exp1.pop_front();
                chk("wr1_addr", 64'(addr1), 64'(e.addr));
                chk("wr1_data", 64'(dout1), 64'(e.data));
                chk("wr1_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        wr1_prev <= wr1;
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dl[i] = 1'b0; m_ovf[i] = 1'b0; m_idx[i] = 8'h00; m_addr[i] = 0;
        end
        m_cmd = 8'h00;
    endtask

    // Effect of one complete byte at position pos of a frame; t is the cycle
    // at which SCK went high for its last bit (write lands 5 cycles later).
    task automatic model_byte(input int pos, input logic [7:0] b, input int t);
        exp_t e;
        if (pos == 0) begin
            m_cmd = b;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_cmd == 8'h55) begin
                    if (pos == 1) m_idx[i] = b;
                end else if (m_cmd == 8'h53) begin
                    if (pos == 1) begin
                        if (b != 8'h00) begin
                            m_dl[i] = 1'b1; m_addr[i] = 0; m_ovf[i] = 1'b0;
                        end else begin
                            m_dl[i] = 1'b0;
                        end
                    end
                end else if (m_cmd == 8'h54) begin
                    if (m_dl[i] && !m_ovf[i]) begin
                        e.addr = 32'(m_addr[i]);
                        e.data = b;
                        e.cyc  = 32'(t + 5);
                        if (i == 0) exp0.push_back(e);
                        else        exp1.push_back(e);
                        if (m_addr[i] == m_max[i]) m_ovf[i] = 1'b1;
                        else                       m_addr[i] = m_addr[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, output int t);
        SPI_DI  = b;
        SPI_SCK = 1'b0;
        tick(HALF);
        SPI_SCK = 1'b1;
        t = cyc;
        tick(HALF);
        SPI_SCK = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int t);
        for (int i = 7; i >= 0; i--) send_bit(b[i], t);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_idx0"}, 64'(index0), 64'(m_idx[0]));
        chk({tag, "_dl0"},  64'(dl0),    64'(m_dl[0]));
        chk({tag, "_adr0"}, 64'(addr0),  64'(m_addr[0]));
        chk({tag, "_ovf0"}, 64'(ovf0),   64'(m_ovf[0]));
        chk({tag, "_idx1"}, 64'(index1), 64'(m_idx[1]));
        chk({tag, "_dl1"},  64'(dl1),    64'(m_dl[1]));
        chk({tag, "_adr1"}, 64'(addr1),  64'(m_addr[1]));
        chk({tag, "_ovf1"}, 64'(ovf1),   64'(m_ovf[1]));
    endtask

    // Sends frame_q as one SS2 frame, then nbits stray bits of a partial byte.
    task automatic send_frame(input string tag, input int nbits);
        int t;
        SPI_SS2 = 1'b0;
        tick(4);
        for (int k = 0; k < frame_q.size(); k++) begin
            send_byte(frame_q[k], t);
            model_byte(k, frame_q[k], t);
        end
        for (int k = 0; k < nbits; k++) send_bit(1'($urandom_range(0, 1)), t);
        tick(4);
        SPI_SS2 = 1'b1;
        tick(10);
        check_regs(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_o0"}, {index0, dl0, addr0, dout0, wr0, ovf0}, 64'd0);
        chk({tag, "_o1"}, {index1, dl1, addr1, dout1, wr1, ovf1}, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int kind;
        logic [7:0] c;
        m_max[0] = (1 << 25) - 1;
        m_max[1] = 15;
        model_reset();

        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(3);
        check_zero("post_reset");

        // Index frame only.
        frame_q = '{8'h55, 8'h05};
        send_frame("idx", 0);
        // Data with no download active.
        frame_q = '{8'h54, 8'h11};
        send_frame("dat_idle", 0);
        // Basic download.
        frame_q = '{8'h53, 8'h01};             send_frame("tx_on", 0);
        frame_q = '{8'h54, 8'hAA, 8'hBB, 8'hCC}; send_frame("dat3", 0);
        frame_q = '{8'h53, 8'h00};             send_frame("tx_off", 0);
        chk("final_addr", 64'(addr0), 64'd3);

        // Partial byte discarded; only 22 is written, at the next address.
        frame_q = '{8'h53, 8'h01}; send_frame("tx_on2", 0);
        frame_q = '{8'h54, 8'h01}; send_frame("dat_a", 0);
        frame_q = '{8'h54};        send_frame("partial", 5);
        frame_q = '{8'h54, 8'h22}; send_frame("dat_b", 0);

        // 17 bytes: the AW=4 instance overflows after address 15.
        frame_q = '{8'h53, 8'h01}; send_frame("tx_on3", 0);
        frame_q = '{8'h54};
        for (int i = 0; i < 17; i++) frame_q.push_back(8'($urandom_range(0, 255)));
        send_frame("ovf", 0);
        chk("ovf_flag1", 64'(ovf1), 64'd1);
        chk("ovf_addr1", 64'(addr1), 64'd15);
        chk("ovf_addr0", 64'(addr0), 64'd17);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 5));
            frame_q.delete();
            case (kind)
                0: begin
                    frame_q.push_back(8'h55);
                    for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                        frame_q.push_back(8'($urandom_range(0, 255)));
                end
                1: begin
                    frame_q.push_back(8'h53);
                    frame_q.push_back(($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                    if ($urandom_range(0, 3) == 0) frame_q.push_back(8'($urandom_range(0, 255)));
                end
                2, 3, 4: begin
                    frame_q.push_back(8'h54);
                    for (int i = 0; i < int'($urandom_range(1, 5)); i++)
                        frame_q.push_back(8'($urandom_range(0, 255)));
                end
                default: begin
                    do c = 8'($urandom_range(0, 255)); while (c >= 8'h53 && c <= 8'h55);
                    frame_q.push_back(c);
                    for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                        frame_q.push_back(8'($urandom_range(0, 255)));
                end
            endcase
            send_frame("rnd", ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : 0);
        end

        // Reset pulse in the middle of a byte during a download.
        frame_q = '{8'h53, 8'h01}; send_frame("tx_on4", 0);
        SPI_SS2 = 1'b0;
        tick(4);
        send_byte(8'h54, t);
        model_byte(0, 8'h54, t);
        send_byte(8'h33, t);
        model_byte(1, 8'h33, t);
        for (int k = 0; k < 3; k++) send_bit(1'b1, t);
        #3;
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        SPI_SCK = 1'b0;
        SPI_SS2 = 1'b1;
        tick(3);
        chk("rst_pending0", 64'(exp0.size()), 64'd0);
        chk("rst_pending1", 64'(exp1.size()), 64'd0);
        model_reset();
        rst = 1'b0;
        tick(3);
        check_zero("rst_rel");
        frame_q = '{8'h53, 8'h01}; send_frame("tx_on5", 0);
        frame_q = '{8'h54, 8'h5A}; send_frame("dat_5a", 0);

        tick(10);
        chk("left0", 64'(exp0.size()), 64'd0);
        chk("left1", 64'(exp1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
